// File: rtl/factorial_accel_if.sv
// Register-bus bundle for the factorial accelerator: byte-wide write/read port plus interrupt.
// Latency: read data is combinational from the address; writes land on the next rising clk edge.
// Backpressure: none, every write is accepted on the edge where the strobe is high.
interface factorial_accel_if;
    logic        writeBus;
    logic [7:0]  dataBusIn;
    logic [31:0] addressBus;
    logic [7:0]  dataBusOut;
    logic        irq;

    modport master (
        output writeBus, dataBusIn, addressBus,
        input  dataBusOut, irq
    );

    modport slave (
        input  writeBus, dataBusIn, addressBus,
        output dataBusOut, irq
    );
endinterface

// File: rtl/factorial_accel.sv
// Memory-mapped iterative factorial engine: N register, CNF control/status, little-endian RESULT bytes.
// Latency: RESULT and done valid max(N,1) edges after the accepted start write; one multiply per edge.
// Backpressure: none; a start written while busy is dropped, all other field writes still apply.
module factorial_accel #(
    parameter int          N_WIDTH   = 8,
    parameter int          FN_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    factorial_accel_if.slave  bus
);
    localparam int FN_BYTES = FN_WIDTH / 8;
    localparam int PW       = FN_WIDTH + N_WIDTH;

    typedef enum logic {IDLE, CALC} state_t;

    state_t                state_q, state_d;
    logic [N_WIDTH-1:0]    n_q, n_d;
    logic [N_WIDTH-1:0]    counter_q, counter_d;
    logic [FN_WIDTH-1:0]   acc_q, acc_d;
    logic [FN_WIDTH-1:0]   result_q, result_d;
    logic                  int_en_q, int_en_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic [31:0]           offset;
    logic                  wr_n, wr_cnf;
    logic                  busy;
    logic [PW-1:0]         prod;

    assign offset = bus.addressBus - BASE_ADDR;
    assign wr_n   = bus.writeBus && (offset == 32'd0);
    assign wr_cnf = bus.writeBus && (offset == 32'd1);
    assign busy   = (state_q == CALC);
    assign bus.irq = done_q & int_en_q;

    // Next-state: register-bus writes first, then the FSM step so a completion overrides a done W1C.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        result_d  = result_q;
        int_en_d  = int_en_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        prod      = PW'(acc_q) * PW'(counter_q);

        if (wr_n) begin
            n_d = bus.dataBusIn[N_WIDTH-1:0];
        end
        if (wr_cnf) begin
            int_en_d = bus.dataBusIn[0];
            if (bus.dataBusIn[2]) begin
                done_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (wr_cnf && bus.dataBusIn[1]) begin
                    counter_d = n_d;
                    acc_d     = FN_WIDTH'(1);
                    done_d    = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (counter_q > N_WIDTH'(1)) begin
                    acc_d     = prod[FN_WIDTH-1:0];
                    counter_d = counter_q - N_WIDTH'(1);
                    if (|prod[PW-1:FN_WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register storage; reset aborts any running computation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            counter_q <= '0;
            acc_q     <= FN_WIDTH'(1);
            result_q  <= '0;
            int_en_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            int_en_q  <= int_en_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Read mux: side-effect free, unmapped offsets return zero.
    always_comb begin
        bus.dataBusOut = 8'h00;
        if (offset == 32'd0) begin
            bus.dataBusOut = 8'(n_q);
        end else if (offset == 32'd1) begin
            bus.dataBusOut = {3'b000, ovf_q, busy, done_q, 1'b0, int_en_q};
        end else begin
            for (int i = 0; i < FN_BYTES; i++) begin
                if (offset == 32'(4 + i)) begin
                    bus.dataBusOut = result_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_factorial_accel.sv
// Self-checking bench for factorial_accel: directed register scenarios plus random N against a factorial model.
// Latency: measures edges from the start write to done against max(N,1).
// Backpressure: none on the bus; every wait on the DUT is bounded by a cycle budget.
module tb_factorial_accel;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    longint unsigned cyc;

    factorial_accel_if bus();

    factorial_accel #(
        .N_WIDTH  (8),
        .FN_WIDTH (32),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [7:0] d);
        @(negedge clk);
        bus.addressBus = BASE + off;
        bus.dataBusIn  = d;
        bus.writeBus   = 1'b1;
        @(posedge clk);
        #1;
        bus.writeBus   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [7:0] v);
        bus.writeBus   = 1'b0;
        bus.addressBus = BASE + off;
        #1;
        v = bus.dataBusOut;
    endtask

    task automatic rd_res(output logic [31:0] r);
        logic [7:0] v;
        for (int b = 0; b < 4; b++) begin
            rd(32'(4 + b), v);
            r[8*b +: 8] = v;
        end
    endtask

    // Reference: n! reduced mod 2^32, overflow when the exact factorial no longer fits in 32 bits.
    function automatic void model(input int n, output logic [31:0] f, output logic ov);
        longint unsigned p;
        p  = 1;
        ov = 1'b0;
        for (int k = 2; k <= n; k++) begin
            p = p * longint'(k);
            if (p > 64'hFFFF_FFFF) ov = 1'b1;
            p = p & 64'hFFFF_FFFF;
        end
        f = p[31:0];
    endfunction

    task automatic wait_done(input longint unsigned e0, output int lat);
        logic [7:0] v;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rd(32'd1, v);
            if (v[2]) begin
                lat = int'(cyc - e0);
                break;
            end
        end
    endtask

    task automatic run(input int n, input logic [7:0] cnf, output int lat);
        logic [7:0] v;
        longint unsigned e0;
        wr(32'd0, 8'(n));
        wr(32'd1, cnf);
        e0 = cyc;
        rd(32'd1, v);
        chk("busy_after_start", {63'd0, v[3]}, 64'd1);
        chk("done_cleared_on_start", {63'd0, v[2]}, 64'd0);
        wait_done(e0, lat);
    endtask

    initial begin
        logic [7:0]  v;
        logic [31:0] r, ef;
        logic        eov;
        int          lat, n;
        logic        ie;
        longint unsigned e0;

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.writeBus   = 1'b0;
        bus.dataBusIn  = 8'h00;
        bus.addressBus = BASE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        rd(32'd0, v);  chk("rst_n", v, 8'h00);
        rd(32'd1, v);  chk("rst_cnf", v, 8'h00);
        rd_res(r);     chk("rst_result", r, 32'd0);
        chk("rst_irq", bus.irq, 1'b0);

        // Unmapped and read-only writes have no effect
        wr(32'd2, 8'hFF);
        wr(32'd5, 8'hAA);
        rd(32'd2, v);  chk("unmapped_read", v, 8'h00);
        rd_res(r);     chk("ro_result_write", r, 32'd0);
        rd(32'd1, v);  chk("cnf_after_unmapped", v, 8'h00);
        wr(32'd1, 8'h18);
        rd(32'd1, v);  chk("cnf_ro_bits_write", v, 8'h00);

        // N=5 with interrupt enabled
        run(5, 8'h03, lat);
        chk("lat_n5", 64'(lat), 64'd5);
        rd(32'd4, v);  chk("res_n5_b0", v, 8'h78);
        rd(32'd5, v);  chk("res_n5_b1", v, 8'h00);
        rd(32'd6, v);  chk("res_n5_b2", v, 8'h00);
        rd(32'd7, v);  chk("res_n5_b3", v, 8'h00);
        rd(32'd8, v);  chk("res_past_end", v, 8'h00);
        chk("irq_n5", bus.irq, 1'b1);
        rd(32'd1, v);  chk("cnf_n5", v, 8'h05);

        // Done W1C keeps int_en, drops irq
        wr(32'd1, 8'h05);
        rd(32'd1, v);  chk("cnf_after_w1c", v, 8'h01);
        chk("irq_after_w1c", bus.irq, 1'b0);

        // W1C landing on the completion edge: set wins
        wr(32'd0, 8'd3);
        wr(32'd1, 8'h03);
        e0 = cyc;
        @(posedge clk);
        @(posedge clk);
        wr(32'd1, 8'h05);
        chk("w1c_edge_alignment", cyc - e0, 64'd3);
        rd(32'd1, v);  chk("done_set_wins", {63'd0, v[2]}, 64'd1);
        chk("irq_set_wins", bus.irq, 1'b1);
        rd_res(r);     chk("res_n3", r, 32'd6);

        // 12! fits, 13! overflows and is truncated
        run(12, 8'h03, lat);
        rd_res(r);     chk("res_n12", r, 32'h1C8C_FC00);
        rd(32'd1, v);  chk("ovf_n12", {63'd0, v[4]}, 64'd0);
        run(13, 8'h03, lat);
        chk("lat_n13", 64'(lat), 64'd13);
        rd_res(r);     chk("res_n13", r, 32'h7328_CC00);
        rd(32'd1, v);  chk("ovf_n13", {63'd0, v[4]}, 64'd1);

        // N=0 and N=1 complete one edge after start; overflow cleared by start
        run(0, 8'h03, lat);
        chk("lat_n0", 64'(lat), 64'd1);
        rd_res(r);     chk("res_n0", r, 32'd1);
        rd(32'd1, v);  chk("ovf_n0", {63'd0, v[4]}, 64'd0);
        run(1, 8'h03, lat);
        chk("lat_n1", 64'(lat), 64'd1);
        rd_res(r);     chk("res_n1", r, 32'd1);

        // Start and N writes while busy: N updates, computation and done unaffected, int_en applies
        wr(32'd0, 8'd6);
        wr(32'd1, 8'h03);
        e0 = cyc;
        wr(32'd0, 8'd3);
        wr(32'd1, 8'h02);
        wait_done(e0, lat);
        chk("lat_busy_restart", 64'(lat), 64'd6);
        rd_res(r);     chk("res_busy_restart", r, 32'd720);
        rd(32'd0, v);  chk("n_written_while_busy", v, 8'd3);
        rd(32'd1, v);  chk("cnf_after_busy_restart", v, 8'h04);
        chk("irq_int_en_cleared", bus.irq, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rd(32'd1, v);  chk("no_second_run", v, 8'h04);
        rd_res(r);     chk("res_held", r, 32'd720);

        // Random operands against the model
        for (int t = 0; t < 8; t++) begin
            n  = int'($urandom_range(0, 20));
            ie = 1'($urandom_range(0, 1));
            model(n, ef, eov);
            run(n, {6'd0, 1'b1, ie}, lat);
            chk($sformatf("rand_lat_n%0d", n), 64'(lat), 64'((n > 1) ? n : 1));
            rd_res(r);
            chk($sformatf("rand_res_n%0d", n), r, ef);
            rd(32'd1, v);
            chk($sformatf("rand_ovf_n%0d", n), {63'd0, v[4]}, {63'd0, eov});
            chk($sformatf("rand_irq_n%0d", n), bus.irq, ie);
        end

        // Reset in the middle of N=10
        wr(32'd0, 8'd10);
        wr(32'd1, 8'h03);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        rd(32'd0, v);  chk("mid_rst_n", v, 8'h00);
        rd(32'd1, v);  chk("mid_rst_cnf", v, 8'h00);
        rd_res(r);     chk("mid_rst_result", r, 32'd0);
        chk("mid_rst_irq", bus.irq, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rd(32'd1, v);  chk("post_rst_no_done", v, 8'h00);
        rd_res(r);     chk("post_rst_result", r, 32'd0);
        rd(32'd2, v);  chk("post_rst_addr2", v, 8'h00);
        chk("post_rst_irq", bus.irq, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/factorial_accel.md
FACTORIAL_ACCEL -- requirements
Module: factorial_accel

Interface
REQ-001 Parameter N_WIDTH, default 8: operand width; legal range 1..8.
REQ-002 Parameter FN_WIDTH, default 32: result width; multiple of 8, range 8..64; FN_BYTES = FN_WIDTH/8.
REQ-003 Parameter BASE_ADDR, default 32'd0: byte address of register block.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 writeBus  input  1  write strobe; write takes effect on the clk edge where it is high.
REQ-007 dataBusIn  input  8  write data.
REQ-008 addressBus  input  32  byte address.
REQ-009 dataBusOut  output  8  read data; combinational from addressBus.
REQ-010 irq  output  1  level interrupt = done AND int_en.

Function
REQ-011 Register map (offset from BASE_ADDR) SHALL be: +0 N (RW, low N_WIDTH bits stored, upper bits read 0); +1 CNF; +4..+3+FN_BYTES RESULT bytes, little-endian, read-only.
REQ-012 CNF bits SHALL be: bit0 int_en RW; bit1 start, write-1 pulse, reads 0; bit2 done, sticky, write-1-clears; bit3 busy RO; bit4 overflow RO, sticky; bits7:5 read 0.
REQ-013 Unmapped addresses SHALL read 8'h00; writes to them and to RO fields SHALL have no effect; reads SHALL have no side effects.
REQ-014 FSM SHALL have states IDLE and CALC.
REQ-015 IDLE: start write at edge E0 SHALL latch counter=N (value after this edge's N write, if simultaneous), acc=1, clear done and overflow, set busy, go CALC.
REQ-016 CALC, counter>1: acc <= low FN_WIDTH bits of acc*counter; counter <= counter-1; overflow set if product bits above FN_WIDTH nonzero.
REQ-017 CALC, counter<=1: RESULT <= acc, done set, busy cleared, go IDLE.
REQ-018 Latency: done and RESULT valid after edge E0+max(N,1); N=0 and N=1 give RESULT=1 after E0+1.
REQ-019 Start written while busy SHALL be ignored; the int_en field of that write still applies.
REQ-020 N writes while busy SHALL update N only; the running computation SHALL be unaffected.
REQ-021 RESULT SHALL hold the previous value until the next completion.
REQ-022 If the done-set and a done W1C occur on the same edge, set SHALL win.
REQ-023 Overflow SHALL remain set until the next accepted start; RESULT SHALL hold the truncated value.

Reset
REQ-024 rst high SHALL asynchronously force: state IDLE, N=0, acc=1, counter=0, RESULT=0, int_en=0, done=0, busy=0, overflow=0, irq=0.
REQ-025 Reset asserted mid-CALC SHALL abort the computation; no done is produced after release.

Verification
REQ-026 Write N=5, then CNF=8'h03 -> busy=1, done after 5 edges, RESULT bytes 78,00,00,00, irq=1, CNF reads 8'h05.
REQ-027 N=12, start -> RESULT 0x1C8CFC00, overflow=0; N=13, start -> RESULT 0x7328CC00, overflow=1, CNF bit4=1.
REQ-028 N=0 and N=1 -> RESULT=1 one edge after start, overflow=0.
REQ-029 Start N=6, write N=3 and start again while busy -> RESULT=720 (0x2D0), one done only.
REQ-030 With done=1, int_en=1: write CNF=8'h05 -> done=0, irq=0, int_en stays 1; W1C coincident with completion -> done=1.
REQ-031 Assert rst during CALC of N=10 -> all registers 0, RESULT=0, no done after release; read of BASE_ADDR+2 -> 8'h00.
